// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops one FIFO word per frame and sends start, DBIT data bits LSB first, then stop.
// tx falls one clk after the fifo_rd pop; the FIFO is read only from IDLE, so an empty FIFO just holds the line idle.
module uart_tx_fifo_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = $clog2(DBIT);

  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, state_next;
  logic [S_W-1:0]    s, s_next;
  logic [N_W-1:0]    n, n_next;
  logic [DBIT-1:0]   b, b_next;
  logic              tx_reg, tx_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      tx_reg <= 1'b1;
    end else begin
      state  <= state_next;
      s      <= s_next;
      n      <= n_next;
      b      <= b_next;
      tx_reg <= tx_next;
    end
  end

  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    case (state)
      IDLE: begin
        // The head word is captured here; later FIFO activity cannot touch the frame in flight.
        if (!fifo_empty) begin
          state_next = START;
          s_next     = '0;
          b_next     = fifo_rdata;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            state_next = DATA;
            s_next     = '0;
            n_next     = '0;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == S_BIT_LAST) begin
            s_next = '0;
            b_next = b >> 1;
            if (n == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == S_STOP_LAST) begin
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    tx_next      = 1'b1;
    if (state == IDLE) begin
      fifo_rd = ~fifo_empty & reset;
    end
    if ((state == STOP) && s_tick && (s == S_STOP_LAST)) begin
      tx_done_tick = reset;
    end
    // Registered line level follows the next state so the start bit lands one edge after the pop.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: an 8-bit/16-tick instance fed from a FIFO model with a tick-counting line monitor,
// plus a 7-bit/32-tick instance driven frame by frame at one s_tick per clk.
module tb_uart_tx_fifo_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b0;
  logic       s_tick = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd, tx, tx_busy, tx_done_tick;

  logic       fifo_empty2 = 1'b1;
  logic [6:0] fifo_rdata2 = 7'h00;
  logic       fifo_rd2, tx2, tx_busy2, tx_done_tick2;

  int n_checks = 0;
  int n_errs   = 0;

  uart_tx_fifo_drain #(.DBIT(8), .SB_TICK(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .fifo_empty   (fifo_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  uart_tx_fifo_drain #(.DBIT(7), .SB_TICK(32)) u_dut7 (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .fifo_empty   (fifo_empty2),
    .fifo_rdata   (fifo_rdata2),
    .fifo_rd      (fifo_rd2),
    .tx           (tx2),
    .tx_busy      (tx_busy2),
    .tx_done_tick (tx_done_tick2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  // Baud strobe: one clk wide every tick_per clocks.
  int tick_per = 4;
  int tcnt     = 0;
  always @(posedge clk) begin
    #1;
    tcnt   = (tcnt + 1 >= tick_per) ? 0 : tcnt + 1;
    s_tick = (tcnt == 0);
  end

  // FIFO model: writes from the stimulus, pops one clk after a fifo_rd seen mid-cycle.
  logic [7:0] wr_buf [64];
  int         wr_cnt = 0;
  int         rd_idx = 0;
  logic       rd_at_neg = 1'b0;
  logic [7:0] sb_q [$];

  assign fifo_empty = (rd_idx == wr_cnt);
  assign fifo_rdata = wr_buf[rd_idx[5:0]];

  always @(posedge clk) begin
    #1;
    if (rd_at_neg && (rd_idx != wr_cnt)) rd_idx++;
  end

  task automatic fifo_write(input logic [7:0] d);
    @(posedge clk);
    #2;
    wr_buf[wr_cnt[5:0]] = d;
    wr_cnt++;
    sb_q.push_back(d);
  endtask

  // Line monitor: counts s_tick pulses from the start-bit edge and samples bit centres.
  logic       mon_active = 1'b0;
  int         mon_k      = 0;
  logic [7:0] mon_byte   = 8'h00;
  logic       done_prev  = 1'b0;
  int         pop_cnt    = 0;
  int         done_cnt   = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mon_active) void'(sb_q.pop_front());
      mon_active = 1'b0;
      rd_at_neg  = 1'b0;
      done_prev  = 1'b0;
    end else begin
      if (rd_at_neg) chk("rd_to_start_tx", tx, 1'b0);
      if (done_prev && !fifo_empty) chk("b2b_rd", fifo_rd, 1'b1);
      if (fifo_rd) begin
        pop_cnt++;
        chk("rd_not_empty", fifo_empty, 1'b0);
      end
      rd_at_neg = fifo_rd;
      done_prev = tx_done_tick;
      if (tx_done_tick) done_cnt++;
      if (!mon_active && tx === 1'b0) begin
        mon_active = 1'b1;
        mon_k      = 0;
        mon_byte   = 8'h00;
      end
      if (mon_active && s_tick) begin
        mon_k++;
        if (mon_k == 8) begin
          chk("start_bit", tx, 1'b0);
          chk("busy_in_frame", tx_busy, 1'b1);
        end else if ((mon_k % 16 == 8) && (mon_k < 144)) begin
          mon_byte[mon_k / 16 - 1] = tx;
        end else if (mon_k == 152) begin
          chk("stop_bit", tx, 1'b1);
        end
        if (mon_k == 160) begin
          chk("done_at_frame_end", tx_done_tick, 1'b1);
          if (sb_q.size() == 0) chk("sb_underflow", 1, 0);
          else                  chk("rx_byte", mon_byte, sb_q.pop_front());
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain(input int budget);
    int t = 0;
    while (!(fifo_empty && sb_q.size() == 0 && !tx_busy && !mon_active) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) chk("drain_timeout", 0, 1);
    else             chk("idle_tx_high", tx, 1'b1);
  endtask

  task automatic frame7(input logic [6:0] d);
    int   bad_done = 0;
    logic exp_bit;
    @(posedge clk);
    #2;
    fifo_rdata2 = d;
    fifo_empty2 = 1'b0;
    #1;
    chk("rd2_pulse", fifo_rd2, 1'b1);
    @(posedge clk);
    #2;
    fifo_empty2 = 1'b1;
    fifo_rdata2 = ~d;
    chk("rd2_one_shot", fifo_rd2, 1'b0);
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (c <= 16)       exp_bit = 1'b0;
      else if (c <= 128) exp_bit = d[(c - 17) / 16];
      else               exp_bit = 1'b1;
      if (c % 16 == 8) chk("tx2_bit", tx2, exp_bit);
      if (tx_done_tick2 !== (c == 160)) bad_done++;
    end
    chk("done2_timing", bad_done, 0);
    @(negedge clk);
    chk("tx2_idle", tx2, 1'b1);
    chk("busy2_idle", tx_busy2, 1'b0);
  endtask

  initial begin
    int t;
    int bad;
    repeat (3) @(posedge clk);
    fifo_write(8'hA5);
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done_tick, 1'b0);
    chk("rst_rd_gated", fifo_rd, 1'b0);
    chk("rst_tx2", tx2, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_drain(3000);

    fifo_write(8'h00);
    fifo_write(8'hFF);
    fifo_write(8'h55);
    wait_drain(6000);

    // Abort 0x3C during data bit 3; 0x96 behind it must go out, 0x3C must not.
    fifo_write(8'h3C);
    fifo_write(8'h96);
    t = 0;
    while (!(mon_active && mon_k >= 72) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_bit3", (t < 3000), 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", tx_busy, 1'b0);
    chk("midrst_done", tx_done_tick, 1'b0);
    chk("midrst_rd_gated", fifo_rd, 1'b0);
    reset = 1'b1;
    wait_drain(3000);

    tick_per = 2;
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fifo_rd || tx !== 1'b1 || tx_busy || tx_done_tick) bad++;
    end
    chk("idle_quiet", bad, 0);

    tick_per = 1;
    frame7(7'h7F);
    frame7(7'h2A);

    chk("total_pops", pop_cnt, 6);
    chk("total_dones", done_cnt, 5);
    chk("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1);
  end

endmodule
